// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and
// standard baud divisors for the 25 MHz system clock.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int DEFAULT_DIV_9600   = 2604;
   localparam int DEFAULT_DIV_115200 = 217;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2,
      ST_WAIT_HIGH
   } rx_state_t;

   // Mode 11 is reserved and behaves like "no parity".
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an idle-high serial line, with a registered
// falling-edge strobe aligned to the first low value on rx_sync.
module uart_rx_sync #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rx_in,
   output logic rx_sync,
   output logic rx_fall
);

   logic [STAGES-1:0] sync_q;

   // Shift the line through the chain; flag the cycle the output first goes low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '1;
         rx_fall <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample its neighbour's
         // old value, which is what makes this a chain rather than a wire.
         sync_q  <= {sync_q[STAGES-2:0], rx_in};
         rx_fall <= sync_q[STAGES-1] & ~sync_q[STAGES-2];
      end
   end

   assign rx_sync = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime baud divisor, optional parity,
// one or two stop bits, framing/parity/break reporting per frame.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int DIV_W       = 24,
   parameter int SYNC_STAGES = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx_in,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   logic                 rx_s;
   logic                 rx_fall;
   rx_state_t            state_q, state_d;
   logic [DIV_W-1:0]     cnt_q;
   logic [DIV_W-1:0]     div_q;
   logic [DIV_W-1:0]     div_eff;
   logic [1:0]           par_q;
   logic                 two_q;
   logic [3:0]           bit_idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 par_bit_q;
   logic                 perr_q;
   logic                 stop1_q;
   logic                 fe_q;
   logic                 bk_q;
   logic                 done_q;
   logic                 tick;
   logic                 par_en;
   logic                 frame_end;
   logic                 brk_base;

   uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .rx_in   (rx_in),
      .rx_sync (rx_s),
      .rx_fall (rx_fall)
   );

   // Divisors below 4 would leave no room for a half-bit start count.
   assign div_eff  = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
   assign tick     = (cnt_q == '0);
   assign par_en   = parity_enabled(par_q);
   assign brk_base = (shreg_q == '0) && (!par_en || !par_bit_q);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; every transition except IDLE/WAIT_HIGH waits for a bit-centre tick.
   always_comb begin
      // NOTE: defaulting state_d first keeps every path assigned, so no latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (rx_fall) state_d = ST_START;
         ST_START:     if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:      if (tick && bit_idx_q == 4'(DATA_BITS-1))
                          state_d = par_en ? ST_PARITY : ST_STOP1;
         ST_PARITY:    if (tick) state_d = ST_STOP1;
         ST_STOP1:     if (tick) state_d = two_q ? ST_STOP2 : (rx_s ? ST_IDLE : ST_WAIT_HIGH);
         ST_STOP2:     if (tick) state_d = (stop1_q && rx_s) ? ST_IDLE : ST_WAIT_HIGH;
         ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs: busy flag and the last-stop-sample strobe.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      frame_end = tick && (((state_q == ST_STOP1) && !two_q) || (state_q == ST_STOP2));
   end

   // Configuration latch at the start edge and the shared bit-timing counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         div_q <= '0;
         par_q <= PAR_NONE;
         two_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (rx_fall) begin
               div_q <= div_eff;
               par_q <= parity_mode;
               two_q <= two_stop;
               cnt_q <= (div_eff >> 1) - DIV_W'(1);
            end
            ST_WAIT_HIGH: ;
            default: cnt_q <= tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
         endcase
      end
   end

   // Bit-centre sampling: data shift, parity check, stop/break evaluation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_idx_q <= '0;
         shreg_q   <= '0;
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
         stop1_q   <= 1'b0;
         fe_q      <= 1'b0;
         bk_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= frame_end;
         if (state_q == ST_IDLE && rx_fall) perr_q <= 1'b0;
         if (tick) begin
            case (state_q)
               ST_START:  bit_idx_q <= '0;
               ST_DATA: begin
                  shreg_q   <= {rx_s, shreg_q[DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + 4'd1;
               end
               ST_PARITY: begin
                  par_bit_q <= rx_s;
                  perr_q    <= ((^shreg_q) ^ rx_s) != (par_q == PAR_ODD);
               end
               ST_STOP1: begin
                  stop1_q <= rx_s;
                  if (!two_q) begin
                     fe_q <= ~rx_s;
                     bk_q <= brk_base & ~rx_s;
                  end
               end
               ST_STOP2: begin
                  fe_q <= ~stop1_q | ~rx_s;
                  bk_q <= brk_base & ~stop1_q;
               end
               default: ;
            endcase
         end
      end
   end

   // Output stage: one-cycle pulses and held data, one clock after the last stop sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         data_valid <= done_q;
         parity_err <= done_q & perr_q;
         frame_err  <= done_q & fe_q;
         break_det  <= done_q & bk_q;
         if (done_q) data_out <= shreg_q;
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames at 16 clocks per bit,
// expected words queued at stimulus time and checked by a monitor on data_valid.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int DIV = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_in = 1'b1;
   logic [23:0] baud_div = 24'(DIV);
   logic [1:0]  parity_mode = PAR_NONE;
   logic        two_stop = 1'b0;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        parity_err;
   logic        frame_err;
   logic        break_det;
   logic        busy;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_valid  = 0;

   uart_rx_cfg #(.DATA_BITS(8), .DIV_W(24), .SYNC_STAGES(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_in       (rx_in),
      .baud_div    (baud_div),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .break_det   (break_det),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
      exp_t e;
      e.data = d;
      e.perr = pe;
      e.ferr = fe;
      e.brk  = bk;
      sb_q.push_back(e);
   endtask

   // Monitor: every data_valid pops one expected frame; stray flags are errors.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (data_valid === 1'b1) begin
         n_valid++;
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got data 0x%0h, expected no pulse", data_out);
         end else begin
            e = sb_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("parity_err", 32'(parity_err), 32'(e.perr));
            check("frame_err", 32'(frame_err), 32'(e.ferr));
            check("break_det", 32'(break_det), 32'(e.brk));
         end
      end else if ((parity_err | frame_err | break_det) === 1'b1) begin
         n_checks++;
         $display("FAIL stray_flag: got pe=%b fe=%b bk=%b without data_valid, expected 0",
                  parity_err, frame_err, break_det);
      end
   end

   task automatic bit_time(input logic v);
      rx_in = v;
      repeat (DIV) @(negedge clk);
   endtask

   // One frame, LSB first; chg_bit >= 0 switches baud_div just before that data bit.
   task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit,
                             input logic s1, input logic use_s2, input logic s2,
                             input int chg_bit);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == chg_bit) baud_div = 24'(DEFAULT_DIV_115200);
         bit_time(d[i]);
      end
      if (use_par) bit_time(pbit);
      bit_time(s1);
      if (use_s2) bit_time(s2);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int   len;
      logic seen;

      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_parity_err", 32'(parity_err), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_break_det", 32'(break_det), 32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: 8N1 back-to-back
      push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
      push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      repeat (2) bit_time(1'b1);
      check("t1_valid_count", 32'(n_valid), 32'd2);

      // 2: even parity, good then bad parity bit
      parity_mode = PAR_EVEN;
      push_exp(8'h07, 1'b0, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
      bit_time(1'b1);
      push_exp(8'h07, 1'b1, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      repeat (2) bit_time(1'b1);
      parity_mode = PAR_NONE;
      check("t2_valid_count", 32'(n_valid), 32'd4);

      // 3: two stop bits, second one low -> frame error, then WAIT_HIGH
      two_stop = 1'b1;
      push_exp(8'h55, 1'b0, 1'b1, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      repeat (2) bit_time(1'b0);
      check("t3_busy_wait_high", 32'(busy), 32'h1);
      check("t3_valid_count", 32'(n_valid), 32'd5);
      rx_in = 1'b1;
      repeat (8) @(negedge clk);
      check("t3_busy_released", 32'(busy), 32'h0);
      two_stop = 1'b0;
      bit_time(1'b1);

      // 4: break, 30 bit times low, then a clean frame
      push_exp(8'h00, 1'b0, 1'b1, 1'b1);
      repeat (30) bit_time(1'b0);
      check("t4_single_pulse", 32'(n_valid), 32'd6);
      check("t4_busy_in_break", 32'(busy), 32'h1);
      repeat (2) bit_time(1'b1);
      push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      repeat (2) bit_time(1'b1);
      check("t4_after_break", 32'(n_valid), 32'd7);

      // 5: 5-clock glitch is rejected at the START sample
      rx_in = 1'b0;
      repeat (5) @(negedge clk);
      rx_in = 1'b1;
      seen = 1'b0;
      len  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      while (seen && busy && len < 40) begin
         @(negedge clk);
         len++;
      end
      check("t5_busy_seen", 32'(seen), 32'h1);
      check("t5_busy_short", 32'(len <= 12), 32'h1);
      repeat (2) bit_time(1'b1);
      check("t5_no_valid", 32'(n_valid), 32'd7);

      // 5b: baud_div changed mid-frame has no effect on that frame
      push_exp(8'hC3, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
      repeat (2) bit_time(1'b1);
      baud_div = 24'(DIV);
      check("t5_div_change", 32'(n_valid), 32'd8);

      // 6: reset during data bit 4, then a clean 0x81
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      bit_time(1'b0);
      bit_time(1'b0);
      rx_in = 1'b0;
      repeat (8) @(negedge clk);
      check("t6_busy_mid_frame", 32'(busy), 32'h1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_data_out", 32'(data_out), 32'h0);
      check("t6_rst_busy", 32'(busy), 32'h0);
      check("t6_rst_valid", 32'(data_valid), 32'h0);
      @(negedge clk);
      rx_in = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) bit_time(1'b1);
      push_exp(8'h81, 1'b0, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      repeat (2) bit_time(1'b1);
      check("t6_valid_count", 32'(n_valid), 32'd9);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Configurable UART receiver. It is the successor to the fixed 8N1 receiver in the tic-tac-toe serial path.
- Adds a runtime baud divisor, 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits.
- Adds false-start rejection, per-byte framing/parity error flags and break detection.
- Feeds the game command decoder. Output is a single-cycle valid pulse with held data.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..9), LSB first
DIV_W, 24, width of the baud divisor input
SYNC_STAGES, 3, number of rx_in synchroniser flops (minimum 2)

Ports:
clk  in  1  system clock (25 MHz on Nexys A7)
reset_n  in  1  asynchronous active-low reset
rx_in  in  1  serial line, idle high
baud_div  in  DIV_W  clocks per bit (2604 = 9600 baud at 25 MHz); values below 4 are treated as 4
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  in  1  0 = one stop bit, 1 = two stop bits
data_out  out  DATA_BITS  last received word, held until next valid
data_valid  out  1  one-cycle pulse per completed frame
parity_err  out  1  one-cycle pulse with data_valid; parity mismatch
frame_err  out  1  one-cycle pulse with data_valid; any stop sample low
break_det  out  1  one-cycle pulse with data_valid; break frame (all samples low)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser flops reset to 1 (line idle).
  - State = IDLE; counters = 0.
  - data_out = 0; all pulses and busy = 0.
- Configuration latch: baud_div, parity_mode and two_stop are latched when a start edge is seen. Changes mid-frame have no effect on that frame.
- Counter: one down-counter, DIV_W bits.
  - At the start edge it loads half = (div>>1)-1.
  - At each sample point it reloads div-1. Every later sample therefore lands at bit centre.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: synchronised rx high→low edge → START; load half-count.
  - START: at counter 0, sample rx.
    - If high (glitch) → IDLE, no outputs.
    - If low → DATA; bit index = 0.
  - DATA: at each counter 0, shift the sample into the MSB of the shift register and increment the bit index.
    - After DATA_BITS samples → PARITY if parity enabled, else STOP1.
  - PARITY: at counter 0, store the sample and compute the error.
    - Even: XOR of data bits and parity bit must be 0.
    - Odd: XOR must be 1.
    - Then → STOP1.
  - STOP1: at counter 0, sample.
    - two_stop=1 → STOP2.
    - Otherwise end of frame.
  - STOP2: at counter 0, sample; end of frame.
  - End of frame: on the next clk edge, assert data_valid for exactly 1 cycle.
    - data_out updates on the same edge.
    - parity_err, frame_err and break_det pulse alongside data_valid.
    - Next state: if any stop sample was 0 → WAIT_HIGH; else → IDLE.
  - WAIT_HIGH: stay until synchronised rx = 1, then → IDLE. This blocks retriggering during a break.
- break_det condition: all data samples 0, parity sample 0 if parity enabled, and STOP1 sample 0. frame_err is also set in this case.
- A frame is always reported even when errors are set; no frame is silently dropped.
- Latency: data_valid rises SYNC_STAGES+1 clocks after the centre of the last stop bit on rx_in.
- A start edge arriving in the same cycle that IDLE is entered is accepted. Back-to-back frames need no idle gap beyond the stop bit(s).
- reset_n asserted mid-frame: everything returns to reset values immediately, with no partial valid.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - rx state encoding;
  - DEFAULT_DIV_9600 = 2604 and DEFAULT_DIV_115200 = 217.
- One sub-module, uart_rx_sync: SYNC_STAGES flop synchroniser, reset-to-1, with a registered falling-edge output. Reused later by the TX loopback checker.

Test Plan:
- Stimulus for all tests: baud_div=16, DATA_BITS=8.
1. 8N1 0xA5, then 0x3C back-to-back → two data_valid pulses, data_out=0xA5 then 0x3C, all error flags 0.
2. parity_mode=01 (even), send 0x07 with parity bit 1 → valid, parity_err=0. Same frame with parity bit 0 → parity_err=1, data_out=0x07.
3. two_stop=1, STOP2 driven low, data 0x55 → data_valid with frame_err=1, data_out=0x55, busy stays high (WAIT_HIGH) until line returns high.
4. Line held low for 30 bit times → one pulse with break_det=1, frame_err=1, data_out=0x00; no second pulse until rx high then a new start.
5. 5-clock low glitch on idle line → no data_valid, busy returns to 0 within 8 clocks after the START sample. Then change baud_div to 217 mid-frame → current byte still decoded at 16.
6. Assert reset_n low during DATA bit 4 → outputs 0 immediately, next clean frame 0x81 decoded correctly.
